fifo_pkt_writer: RTL

// - Write-side producer for the dual-clock 8-bit byte FIFO; runs entirely in the wr_clk domain.
// - Frames each upstream byte stream as one packet in the FIFO: a length header byte, then the payload bytes.
// - Drives the FIFO wr/data_in pins and never writes while the FIFO reports full.
// - Sits between a wr_clk-domain byte source (valid/ready) and the FIFO write port.

---
 rtl/fifo_pkt_writer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_pkt_writer.sv
// Write-side packet framer for the dual-clock byte FIFO: emits a length header, then the payload.
// Optional trailer checksum byte when FIFO_PKT_WRITER_CHECKSUM_EN is defined.
module fifo_pkt_writer #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              wr_clk,
    input  logic              reset_n,
    input  logic              pkt_start,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_data,
    output logic              busy,
    output logic              done
);

`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, PAY, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               done_q, done_d;
    logic               last_write;
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
    logic [DATA_W-1:0]  checksum_q, checksum_d;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        last_write  = 1'b0;
        fifo_wr     = 1'b0;
        fifo_data   = '0;
        s_ready     = 1'b0;
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (pkt_start) begin
                    remaining_d = pkt_len;
                    state_d     = HDR;
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
                    checksum_d  = '0;
`endif
                end
            end
            HDR: begin
                // remaining is untouched until the header is written, so it still holds the length
                fifo_data = DATA_W'(remaining_q);
                fifo_wr   = !fifo_full;
                if (!fifo_full) begin
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
                    checksum_d = checksum_q ^ DATA_W'(remaining_q);
`endif
                    if (remaining_q != '0) begin
                        state_d = PAY;
                    end else begin
                        last_write = 1'b1;
                    end
                end
            end
            PAY: begin
                s_ready   = !fifo_full;
                fifo_data = s_data;
                fifo_wr   = s_valid && !fifo_full;
                if (s_valid && !fifo_full) begin
                    remaining_d = remaining_q - LEN_W'(1);
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
                    checksum_d  = checksum_q ^ s_data;
`endif
                    if (remaining_q == LEN_W'(1)) begin
                        last_write = 1'b1;
                    end
                end
            end
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
            CSUM: begin
                fifo_data = checksum_q;
                fifo_wr   = !fifo_full;
                if (!fifo_full) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (last_write) begin
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule
